// File: rtl/weightbuffer_loader.sv
// Weight buffer loader: flushes the selected buffer set, then steers each
// accepted weight word to its (set, stagger, k1, k2) slot via one-hot save enables.
module weightbuffer_loader #(
    parameter int N_I            = 512,
    parameter int WEIGHT_STAGGER = 2,
    parameter int K              = 3
) (
    input  logic                                                  clk_i,
    input  logic                                                  rst_i,
    input  logic                                                  cmd_valid_i,
    output logic                                                  cmd_ready_o,
    input  logic                                                  cmd_set_i,
    input  logic                                                  cmd_pointwise_i,
    input  logic                                                  weight_valid_i,
    output logic                                                  weight_ready_o,
    input  logic [N_I/WEIGHT_STAGGER*2-1:0]                       weight_i,
    output logic [N_I/WEIGHT_STAGGER*2-1:0]                       data_o,
    output logic [0:1][0:WEIGHT_STAGGER-1][0:K-1][0:K-1]          save_enable_o,
    output logic [0:1][0:WEIGHT_STAGGER-1]                        flush_o,
    output logic                                                  busy_o,
    output logic                                                  done_o
);

    localparam int WS = WEIGHT_STAGGER;
    localparam int DW = N_I / WS * 2;
    localparam int SW = (WS > 1) ? $clog2(WS) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_LOAD,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   stg_q, stg_d;
    logic [KW-1:0]   k1_q, k1_d;
    logic [KW-1:0]   k2_q, k2_d;
    logic            set_q, set_d;
    logic            pw_q, pw_d;
    logic [DW-1:0]   data_q, data_d;
    logic [0:1][0:WS-1][0:K-1][0:K-1] save_q, save_d;

    logic [KW-1:0]   k1_idx, k2_idx;
    logic            last_beat;

    // Pointwise loads address the centre tap while the k counters stay at zero.
    assign k1_idx    = pw_q ? KW'(K / 2) : k1_q;
    assign k2_idx    = pw_q ? KW'(K / 2) : k2_q;
    assign last_beat = (stg_q == SW'(WS - 1)) &&
                       (pw_q || ((k1_q == KW'(K - 1)) && (k2_q == KW'(K - 1))));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            stg_q   <= '0;
            k1_q    <= '0;
            k2_q    <= '0;
            set_q   <= 1'b0;
            pw_q    <= 1'b0;
            data_q  <= '0;
            save_q  <= '0;
        end else begin
            state_q <= state_d;
            stg_q   <= stg_d;
            k1_q    <= k1_d;
            k2_q    <= k2_d;
            set_q   <= set_d;
            pw_q    <= pw_d;
            data_q  <= data_d;
            save_q  <= save_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stg_d   = stg_q;
        k1_d    = k1_q;
        k2_d    = k2_q;
        set_d   = set_q;
        pw_d    = pw_q;
        data_d  = data_q;
        save_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    state_d = S_FLUSH;
                    set_d   = cmd_set_i;
                    pw_d    = cmd_pointwise_i;
                    stg_d   = '0;
                    k1_d    = '0;
                    k2_d    = '0;
                end
            end
            S_FLUSH: state_d = S_LOAD;
            S_LOAD: begin
                if (weight_valid_i) begin
                    data_d = weight_i;
                    save_d[set_q][stg_q][k1_idx][k2_idx] = 1'b1;
                    // Stagger innermost, then k2, then k1; counters hold on the last beat.
                    if (last_beat) begin
                        state_d = S_DONE;
                    end else if (stg_q == SW'(WS - 1)) begin
                        stg_d = '0;
                        if (k2_q == KW'(K - 1)) begin
                            k2_d = '0;
                            k1_d = k1_q + KW'(1);
                        end else begin
                            k2_d = k2_q + KW'(1);
                        end
                    end else begin
                        stg_d = stg_q + SW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        flush_o = '0;
        if (state_q == S_FLUSH) begin
            flush_o[set_q] = '1;
        end
    end

    assign cmd_ready_o    = (state_q == S_IDLE);
    assign weight_ready_o = (state_q == S_LOAD);
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = (state_q == S_DONE);
    assign data_o         = data_q;
    assign save_enable_o  = save_q;

endmodule
